// File: rtl/serv_wb_ram.sv
// Wishbone-attached byte-lane RAM with configurable wait states, range checking and abort.
// Memory contents are not reset; only the handshake state is.
module serv_wb_ram #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int WORDS = DEPTH / 4;
    localparam int IW    = (AW > 2) ? AW - 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdt_q, rdt_d;
    logic        resp_s;
    logic        range_err_s;
    logic [IW-1:0] rd_idx_s;
    logic [IW-1:0] wr_idx_s;

    logic [31:0] mem_q [0:WORDS-1];

    // The response is decided from the request as it will be held once captured,
    // so a zero-wait-state request can respond straight out of IDLE.
    assign range_err_s = (adr_d >> AW) != 32'd0;
    assign rd_idx_s    = adr_d[IW+1:2];
    assign wr_idx_s    = adr_q[IW+1:2];

    // Next-state, capture and response computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        resp_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_wb_cyc) begin
                    adr_d = i_wb_adr;
                    dat_d = i_wb_dat;
                    sel_d = i_wb_sel;
                    we_d  = i_wb_we;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        resp_s  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end else begin
                    cnt_d = 4'd0;
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    resp_s  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        ack_d = resp_s & ~range_err_s;
        err_d = resp_s & range_err_s;
        if (resp_s && !range_err_s && !we_d) begin
            rdt_d = mem_q[rd_idx_s];
        end else begin
            rdt_d = 32'd0;
        end
    end

    // Handshake state and registered bus outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdt_q   <= rdt_d;
        end
    end

    // Byte-lane write at the end of an acknowledged write; reset here cancels it
    always_ff @(posedge i_clk) begin
        if (!i_rst && state_q == RESP && ack_q && we_q) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) begin
                    mem_q[wr_idx_s][8*n +: 8] <= dat_q[8*n +: 8];
                end
            end
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_err = err_q;
    assign o_wb_rdt = rdt_q;

endmodule

// File: tb/tb_serv_wb_ram.sv
// Directed bench for serv_wb_ram: one instance with no wait states, one with three,
// sharing the request bus and selected by 'which'.
module tb_serv_wb_ram;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic        cyc, which;
    logic        cyc0, cyc3;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdt0, rdt3, rdt;
    logic        ack0, ack3, ack;
    logic        err0, err3, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign cyc0 = cyc & ~which;
    assign cyc3 = cyc & which;
    assign ack  = which ? ack3 : ack0;
    assign err  = which ? err3 : err0;
    assign rdt  = which ? rdt3 : rdt0;

    serv_wb_ram #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_rst(rst0), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc0), .o_wb_rdt(rdt0), .o_wb_ack(ack0), .o_wb_err(err0)
    );

    serv_wb_ram #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_rst(rst3), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc3), .o_wb_rdt(rdt3), .o_wb_ack(ack3), .o_wb_err(err3)
    );

    typedef struct {
        bit          ws3;
        bit          wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          exp_err;
        bit          chk_rdt;
        logic [31:0] exp_rdt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit ws3, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input bit e, input bit c, input logic [31:0] r);
        vec_t v;
        v.ws3 = ws3; v.wr = wr; v.adr = a; v.dat = d; v.sel = s;
        v.exp_err = e; v.chk_rdt = c; v.exp_rdt = r;
        return v;
    endfunction

    // One transaction starting #1 after a rising edge; returns #1 after the edge ending the
    // response cycle. Request inputs are scrambled once captured to show they are ignored.
    task automatic xfer(input bit w3, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit got_ack, output bit got_err,
                        output logic [31:0] got_rdt, output int lat, output bit leak);
        which = w3; we = wr; adr = a; dat = d; sel = s; cyc = 1'b1;
        got_ack = 1'b0; got_err = 1'b0; got_rdt = 32'd0; lat = -1; leak = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack || err) begin
                got_ack = ack; got_err = err; got_rdt = rdt; lat = c;
                break;
            end
            if (rdt !== 32'd0) leak = 1'b1;
            @(posedge clk); #1;
            adr = ~a & 32'h0000_00FC; dat = ~d; sel = ~s; we = ~wr;
        end
        @(posedge clk); #1;
        cyc = 1'b0;
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        bit seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (ack || err) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit ga, ge, lk;
        logic [31:0] gr;
        int lat, exp_lat;

        rst0 = 1'b1; rst3 = 1'b1; cyc = 1'b0; which = 1'b0;
        adr = 32'd0; dat = 32'd0; sel = 4'd0; we = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ack0", {31'd0, ack0}, 32'd0);
        check("rst.err0", {31'd0, err0}, 32'd0);
        check("rst.rdt0", rdt0, 32'd0);
        check("rst.ack3", {31'd0, ack3}, 32'd0);
        check("rst.err3", {31'd0, err3}, 32'd0);
        check("rst.rdt3", rdt3, 32'd0);
        @(posedge clk); #1;
        rst0 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;

        vecs[0]  = mk(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'hDEAD_BEEF);
        vecs[2]  = mk(1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0100, 1'b0, 1'b0, 32'd0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'hDE22_BEEF);
        vecs[4]  = mk(1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'd0);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0001, 1'b0, 1'b1, 32'hDE22_BEEF);
        vecs[6]  = mk(1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, 32'd0);
        vecs[7]  = mk(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1111, 1'b1, 1'b1, 32'd0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'b1111, 1'b1, 1'b1, 32'd0);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'hCAFE_F00D);
        vecs[10] = mk(1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 4'b1000, 1'b0, 1'b1, 32'hDE22_BEEF);
        vecs[11] = mk(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1111, 1'b1, 1'b1, 32'd0);
        vecs[12] = mk(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'b1111, 1'b0, 1'b0, 32'd0);
        vecs[13] = mk(1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'hA5A5_A5A5);
        vecs[14] = mk(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'b1111, 1'b1, 1'b1, 32'd0);

        foreach (vecs[i]) begin
            exp_lat = vecs[i].ws3 ? 4 : 1;
            xfer(vecs[i].ws3, vecs[i].wr, vecs[i].adr, vecs[i].dat, vecs[i].sel, ga, ge, gr, lat, lk);
            check($sformatf("vec%0d.ack", i), {31'd0, ga}, {31'd0, ~vecs[i].exp_err});
            check($sformatf("vec%0d.err", i), {31'd0, ge}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d.latency", i), lat, exp_lat);
            check($sformatf("vec%0d.rdt_idle", i), {31'd0, lk}, 32'd0);
            if (vecs[i].chk_rdt) check($sformatf("vec%0d.rdt", i), gr, vecs[i].exp_rdt);
            @(posedge clk); #1;
        end

        // Abort: cyc dropped while the 3-wait-state write is still waiting
        which = 1'b1; we = 1'b1; adr = 32'h0000_0020; dat = 32'h5A5A_5A5A; sel = 4'b1111; cyc = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        cyc = 1'b0;
        watch_quiet("abort.no_resp", 10);
        xfer(1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'b1111, ga, ge, gr, lat, lk);
        check("abort.rdt", gr, 32'hA5A5_A5A5);
        check("abort.latency", lat, 4);
        @(posedge clk); #1;

        // Reset while waiting: write cancelled, next request starts from IDLE
        which = 1'b1; we = 1'b1; adr = 32'h0000_0020; dat = 32'h7777_7777; sel = 4'b1111; cyc = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0; cyc = 1'b0;
        watch_quiet("rstwait.no_resp", 10);
        xfer(1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'b1111, ga, ge, gr, lat, lk);
        check("rstwait.rdt", gr, 32'hA5A5_A5A5);
        check("rstwait.latency", lat, 4);
        check("rstwait.ack", {31'd0, ga}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back: each new request starts the cycle after the previous ack
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'hA0B0_C0D0 ^ (32'h1111_1111 * 32'(i)),
                 4'b1111, ga, ge, gr, lat, lk);
            check($sformatf("b2b.wr%0d.ack", i), {31'd0, ga}, 32'd1);
            check($sformatf("b2b.wr%0d.latency", i), lat, 1);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 1'b0, 32'h40 + 32'(4 * i), 32'd0, 4'b1111, ga, ge, gr, lat, lk);
            check($sformatf("b2b.rd%0d.latency", i), lat, 1);
            check($sformatf("b2b.rd%0d.rdt", i), gr, 32'hA0B0_C0D0 ^ (32'h1111_1111 * 32'(i)));
        end
        watch_quiet("b2b.no_extra_ack", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
